hline_motion_ctrl: RTL and testbench
====================================

// Module: hline_motion_ctrl
// PURPOSE
// Command-side controller for the horizontal-line position counter. It issues the single-cycle
// UP / DW / LD commands to the counter and consumes its terminal flags (UTC at top row 630,
// DTC at bottom row 18). The result is a line that bounces between the two limits at a
// frame-locked, switch-selected speed.
// Sits between the button/VGA-timing logic and the line position counter.
// PARAMETERS
// DIV_W     4    width of the speed selector and the frame divider
// BNC_W     8    width of the saturating bounce counter
// START_DIR 1    direction after reset or stop; 1 = UP, 0 = DW
// PORTS
// clk        in   1      system clock; all logic on rising edge
// reset      in   1      synchronous, active-low reset
// frame      in   1      one-cycle pulse per video frame
// go         in   1      one-cycle pulse (debounced btn): start or resume
// stop       in   1      one-cycle pulse: pause, or abort when already paused
// load_btn   in   1      one-cycle pulse: request counter load from switches
// speed      in   DIV_W  move one row every speed+1 frames
// utc_in     in   1      counter at top limit (630)
// dtc_in     in   1      counter at bottom limit (18)
// UP         out  1      one-cycle count-up command to counter
// DW         out  1      one-cycle count-down command to counter
// LD         out  1      one-cycle load command to counter
// dir        out  1      current direction, 1 = UP
// moving     out  1      high in RUN
// fault      out  1      sticky; utc_in and dtc_in seen together on a step
// bounce_cnt out  BNC_W  number of reversals, saturating
// BEHAVIOUR
// - Reset (reset==0 at edge): state IDLE, UP=DW=LD=0, dir=START_DIR, moving=0, fault=0,
//   bounce_cnt=0, divider=0.
// - All outputs are registered. At most one of UP/DW/LD is high in any cycle. Each command
//   is exactly one cycle wide.
// - States: IDLE, RUN, PAUSE.
//   IDLE  -go->    RUN; divider cleared
//   IDLE  -load_btn-> LD pulse next cycle, stays IDLE, clears fault
//   RUN   -stop->  PAUSE
//   PAUSE -go->    RUN; divider kept
//   PAUSE -stop->  IDLE; dir=START_DIR
// - go and stop in the same cycle: stop wins. load_btn is ignored outside IDLE.
// - RUN step rule: on each frame pulse, if divider >= speed then divider<=0 and one step is
//   taken; otherwise divider<=divider+1. The comparison is >= so a speed lowered mid-run
//   takes effect on the next frame.
// - Step decision is made on the flags sampled in the frame cycle. The command appears 1 clk
//   after the frame pulse.
//   dir=UP, utc_in=0  -> UP pulse
//   dir=UP, utc_in=1  -> dir<=DW, DW pulse, bounce_cnt++
//   dir=DW, dtc_in=0  -> DW pulse
//   dir=DW, dtc_in=1  -> dir<=UP, UP pulse, bounce_cnt++
//   utc_in=1 and dtc_in=1 -> no command, fault<=1, state<=IDLE
// - Flag outside the current direction (e.g. dtc_in while dir=UP) is ignored; a position
//   loaded outside 18..630 is driven toward range with no reversal.
// - bounce_cnt holds at all-ones. It is cleared only by reset.
// - stop arriving in the same cycle as a step frame: stop wins, no command issued.
// - Reset mid-RUN: any command pulse scheduled for the next cycle is suppressed; outputs
//   return to reset values at that edge.
// STRUCTURE
// - Shared package hline_pkg: state encoding (IDLE/RUN/PAUSE), DIR_UP=1'b1 / DIR_DW=1'b0,
//   row limits Y_TOP=630 and Y_BOT=18 (also used by the counter flags).
// - One sub-module, hline_step_div: frame-pulse divider with clear, hold and >= compare.
//   It outputs a one-cycle step_en.
// - Top level holds the FSM, direction and bounce logic, and the registered command outputs.
// TESTING
// 1 reset=0 for 2 clk, then reset=1
//   -> all outputs 0 except dir=1; 10 frames with no go produce no UP/DW.
// 2 IDLE, load_btn pulse
//   -> LD=1 for exactly 1 clk, the clk after; fault cleared; go+load_btn in RUN gives no LD.
// 3 go, speed=0, dtc/utc=0
//   -> UP pulse 1 clk after every frame; with speed=2, one UP every 3rd frame (frames 3, 6, 9).
// 4 RUN dir=UP, utc_in=1 at frame
//   -> DW pulse, dir=0, bounce_cnt=1; then dtc_in=1 -> UP pulse, dir=1, bounce_cnt=2;
//      256 bounces saturate at 255.
// 5 stop in RUN -> PAUSE, no pulses; go resumes same dir; stop, stop -> IDLE, dir=1;
//   go+stop same cycle -> stop.
// 6 utc_in=dtc_in=1 at step -> no command, fault=1, IDLE; reset=0 during RUN the cycle after
//   a step frame -> no UP/DW pulse emitted.

Source files
------------

// File: rtl/hline_pkg.sv
// Shared definitions for the horizontal-line motion controller and its position counter.
package hline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } hline_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DW = 1'b0;

  // Row limits; the counter raises utc/dtc at these positions.
  localparam int unsigned Y_TOP = 630;
  localparam int unsigned Y_BOT = 18;

endpackage

// File: rtl/hline_step_div.sv
// Frame-pulse divider: one step_en every speed+1 frames while enabled.
module hline_step_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             frame,
  input  logic [DIV_W-1:0] speed,
  output logic             step_en
);

  logic [DIV_W-1:0] div;

  // >= rather than == so that lowering speed mid-run takes effect on the next frame.
  assign step_en = en && frame && (div >= speed);

  always_ff @(posedge clk) begin
    if (!reset) begin
      div <= '0;
    end else if (clr) begin
      div <= '0;
    end else if (en && frame) begin
      if (div >= speed) div <= '0;
      else              div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/hline_motion_ctrl.sv
// Command-side controller for the line position counter: bounces the line between row limits.
module hline_motion_ctrl
  import hline_pkg::*;
#(
  parameter int DIV_W     = 4,
  parameter int BNC_W     = 8,
  parameter bit START_DIR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame,
  input  logic             go,
  input  logic             stop,
  input  logic             load_btn,
  input  logic [DIV_W-1:0] speed,
  input  logic             utc_in,
  input  logic             dtc_in,
  output logic             UP,
  output logic             DW,
  output logic             LD,
  output logic             dir,
  output logic             moving,
  output logic             fault,
  output logic [BNC_W-1:0] bounce_cnt
);

  // state    | meaning
  // ST_IDLE  | stopped; load_btn issues LD and clears fault
  // ST_RUN   | stepping on divided frame pulses, reversing at the limits
  // ST_PAUSE | frozen; go resumes with divider and direction kept, stop aborts to IDLE

  hline_state_e state, state_n;
  logic             dir_n, fault_n, up_n, dw_n, ld_n, div_clr, div_en, step_en;
  logic [BNC_W-1:0] bnc_n;

  assign div_en  = (state == ST_RUN) && !stop;
  assign div_clr = (state == ST_IDLE) && go && !stop;

  hline_step_div #(.DIV_W(DIV_W)) u_div (
    .clk     (clk),
    .reset   (reset),
    .clr     (div_clr),
    .en      (div_en),
    .frame   (frame),
    .speed   (speed),
    .step_en (step_en)
  );

  always_comb begin
    state_n = state;
    dir_n   = dir;
    fault_n = fault;
    bnc_n   = bounce_cnt;
    up_n    = 1'b0;
    dw_n    = 1'b0;
    ld_n    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (stop) begin
          state_n = ST_IDLE;
        end else if (go) begin
          state_n = ST_RUN;
        end else if (load_btn) begin
          ld_n    = 1'b1;
          fault_n = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n = ST_PAUSE;
        end else if (step_en) begin
          if (utc_in && dtc_in) begin
            fault_n = 1'b1;
            state_n = ST_IDLE;
          end else if (dir == DIR_UP) begin
            if (utc_in) begin
              dir_n = DIR_DW;
              dw_n  = 1'b1;
              if (bounce_cnt != '1) bnc_n = bounce_cnt + 1'b1;
            end else begin
              up_n = 1'b1;
            end
          end else begin
            if (dtc_in) begin
              dir_n = DIR_UP;
              up_n  = 1'b1;
              if (bounce_cnt != '1) bnc_n = bounce_cnt + 1'b1;
            end else begin
              dw_n = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_n = ST_IDLE;
          dir_n   = START_DIR;
        end else if (go) begin
          state_n = ST_RUN;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      dir        <= START_DIR;
      fault      <= 1'b0;
      bounce_cnt <= '0;
      UP         <= 1'b0;
      DW         <= 1'b0;
      LD         <= 1'b0;
      moving     <= 1'b0;
    end else begin
      state      <= state_n;
      dir        <= dir_n;
      fault      <= fault_n;
      bounce_cnt <= bnc_n;
      UP         <= up_n;
      DW         <= dw_n;
      LD         <= ld_n;
      moving     <= (state_n == ST_RUN);
    end
  end

endmodule

// File: tb/tb_hline_motion_ctrl.sv
// Directed bench for hline_motion_ctrl with a reference model feeding an expected-result queue.
module tb_hline_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset, frame, go, stop, load_btn, utc_in, dtc_in;
  logic [3:0] speed;
  logic       UP, DW, LD, dir, moving, fault;
  logic [7:0] bounce_cnt;

  hline_motion_ctrl #(.DIV_W(4), .BNC_W(8), .START_DIR(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame      (frame),
    .go         (go),
    .stop       (stop),
    .load_btn   (load_btn),
    .speed      (speed),
    .utc_in     (utc_in),
    .dtc_in     (dtc_in),
    .UP         (UP),
    .DW         (DW),
    .LD         (LD),
    .dir        (dir),
    .moving     (moving),
    .fault      (fault),
    .bounce_cnt (bounce_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       up, dw, ld, dir, moving, fault;
    logic [7:0] bcnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   m_state, m_div, m_bcnt;
  logic m_dir, m_fault;
  logic last_up;
  logic [8:0] hits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Inputs are set at a negedge; this models the coming edge, waits for it and compares.
  task automatic tick();
    exp_t e, got;
    e = '0;
    if (!reset) begin
      m_state = 0; m_div = 0; m_dir = 1'b1; m_fault = 1'b0; m_bcnt = 0;
    end else begin
      case (m_state)
        0: if (!stop) begin
             if (go) begin m_state = 1; m_div = 0; end
             else if (load_btn) begin e.ld = 1'b1; m_fault = 1'b0; end
           end
        1: if (stop) m_state = 2;
           else if (frame) begin
             if (m_div >= int'(speed)) begin
               m_div = 0;
               if (utc_in && dtc_in) begin m_fault = 1'b1; m_state = 0; end
               else if (m_dir) begin
                 if (utc_in) begin m_dir = 1'b0; e.dw = 1'b1; if (m_bcnt != 255) m_bcnt++; end
                 else e.up = 1'b1;
               end else begin
                 if (dtc_in) begin m_dir = 1'b1; e.up = 1'b1; if (m_bcnt != 255) m_bcnt++; end
                 else e.dw = 1'b1;
               end
             end else m_div++;
           end
        default: if (stop) begin m_state = 0; m_dir = 1'b1; end
                 else if (go) m_state = 1;
      endcase
    end
    e.dir = m_dir; e.moving = (m_state == 1); e.fault = m_fault; e.bcnt = m_bcnt[7:0];
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = exp_q.pop_front();
    last_up = UP;
    chk("cmd",    {UP, DW, LD}, {got.up, got.dw, got.ld});
    chk("onehot", $onehot0({UP, DW, LD}), 1);
    chk("dir",    dir,        got.dir);
    chk("moving", moving,     got.moving);
    chk("fault",  fault,      got.fault);
    chk("bcnt",   bounce_cnt, got.bcnt);
    frame = 0; go = 0; stop = 0; load_btn = 0;
  endtask

  initial begin
    reset = 0; frame = 0; go = 0; stop = 0; load_btn = 0; utc_in = 0; dtc_in = 0; speed = 0;
    @(negedge clk);

    // 1: reset, then idle frames produce nothing
    tick(); tick();
    reset = 1;
    for (int i = 0; i < 10; i++) begin frame = 1; tick(); end

    // 2: load in IDLE
    load_btn = 1; tick();
    tick();

    // 3: run at speed 0, then speed 2
    go = 1; tick();
    for (int i = 0; i < 4; i++) begin frame = 1; tick(); end
    go = 1; load_btn = 1; tick();
    speed = 2;
    hits = '0;
    for (int i = 0; i < 9; i++) begin frame = 1; tick(); hits[i] = last_up; end
    chk("spd2_frames", hits, 9'b100100100);

    // 4: bounces and saturation
    speed = 0;
    utc_in = 1; frame = 1; tick();
    utc_in = 0; dtc_in = 1; frame = 1; tick();
    dtc_in = 0;
    for (int i = 0; i < 254; i++) begin
      utc_in = m_dir; dtc_in = ~m_dir; frame = 1; tick();
    end
    utc_in = 0; dtc_in = 0;
    chk("bnc_sat", bounce_cnt, 8'd255);
    // flag outside current direction is ignored
    dtc_in = m_dir; utc_in = ~m_dir & 1'b0; frame = 1; tick();
    dtc_in = 0;

    // 5: pause / resume / abort
    utc_in = 1; frame = 1; tick();
    utc_in = 0;
    stop = 1; tick();
    for (int i = 0; i < 3; i++) begin frame = 1; tick(); end
    go = 1; tick();
    frame = 1; tick();
    stop = 1; tick();
    stop = 1; tick();
    go = 1; tick();
    go = 1; stop = 1; tick();
    go = 1; tick();
    frame = 1; stop = 1; tick();
    go = 1; tick();
    speed = 3;
    frame = 1; tick();
    speed = 0;
    frame = 1; tick();

    // 6: double flag fault, load clears it, reset suppresses a scheduled step
    utc_in = 1; dtc_in = 1; frame = 1; tick();
    utc_in = 0; dtc_in = 0;
    frame = 1; tick();
    load_btn = 1; tick();
    go = 1; tick();
    frame = 1; tick();
    frame = 1; reset = 0; tick();
    chk("rst_no_up", last_up, 0);
    reset = 1; tick();
    frame = 1; tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
